// File: rtl/sprite_select_arbiter_if.sv
// Sprite arbiter bus: per-frame request sampling in, registered grant out.
//
// Handshake: the master drives frame_start (one-cycle pulse per frame), the
// request vector sprites and ack (the image for the current grant is loaded).
// The slave answers with selected/valid one cycle after the sampling frame;
// valid stays high for as long as a grant is held. The grant is released on
// a frame_start once the hold count has expired and ack has been seen
// during the grant. overrun is a sticky flag raised when a nonzero request
// is dropped because a grant is still held.
interface sprite_select_arbiter_if #(
  parameter int N     = 14,
  parameter int IDX_W = 4
);
  logic             frame_start;
  logic [N-1:0]     sprites;
  logic             ack;
  logic [IDX_W-1:0] selected;
  logic             valid;
  logic             overrun;

  modport master (
    output frame_start, sprites, ack,
    input  selected, valid, overrun
  );

  modport slave (
    input  frame_start, sprites, ack,
    output selected, valid, overrun
  );
endinterface

// File: rtl/sprite_select_arbiter.sv
// Sprite select arbiter: picks one sprite per frame (fixed priority or
// round-robin) and holds the grant for at least HOLD_FRAMES frames and
// until the consumer acknowledges the image load.
module sprite_select_arbiter #(
  parameter int N           = 14,
  parameter int IDX_W       = 4,
  parameter int RR          = 0,
  parameter int HOLD_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sprite_select_arbiter_if.slave bus,
  output logic [0:0]            dbg_state_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  localparam int               CNT_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_seen_q, ack_seen_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] scan_pos;
  logic             req_any;
  logic             rel_now;

  assign req_any = (bus.sprites != '0);

  // Winner search: highest set bit, or first set bit walking down from ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = '0;
    if (RR == 0) begin
      for (int k = 0; k < N; k++) begin
        if (bus.sprites[k]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(k);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        scan_pos = IDX_W'((int'(ptr_q) + N - i) % N);
        if (!win_found && bus.sprites[scan_pos]) begin
          win_found = 1'b1;
          win_idx   = scan_pos;
        end
      end
    end
  end

  // Release is only considered on a frame boundary; ack on the same cycle counts.
  assign rel_now = (cnt_q == '0) && (ack_seen_q || bus.ack);

  // Next-state logic for the IDLE/SHOW grant controller.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    cnt_d      = cnt_q;
    ack_seen_d = ack_seen_q;
    ptr_d      = ptr_q;

    case (state_q)
      ST_IDLE: begin
        // ack here is deliberately ignored so it cannot pre-arm a future release.
        if (bus.frame_start && win_found) begin
          state_d    = ST_SHOW;
          sel_d      = win_idx + 1'b1;
          valid_d    = 1'b1;
          cnt_d      = CNT_LOAD;
          ack_seen_d = 1'b0;
          if (RR != 0) ptr_d = (win_idx == '0) ? PTR_RST : win_idx - 1'b1;
        end
      end
      ST_SHOW: begin
        if (bus.ack) ack_seen_d = 1'b1;
        if (bus.frame_start) begin
          if (rel_now) begin
            if (win_found) begin
              sel_d      = win_idx + 1'b1;
              valid_d    = 1'b1;
              cnt_d      = CNT_LOAD;
              ack_seen_d = 1'b0;
              if (RR != 0) ptr_d = (win_idx == '0) ? PTR_RST : win_idx - 1'b1;
            end else begin
              state_d    = ST_IDLE;
              sel_d      = '0;
              valid_d    = 1'b0;
              ack_seen_d = 1'b0;
            end
          end else begin
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            if (req_any) ovr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; synchronous reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      cnt_q      <= '0;
      ack_seen_q <= 1'b0;
      ptr_q      <= PTR_RST;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      cnt_q      <= cnt_d;
      ack_seen_q <= ack_seen_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.selected = sel_q;
  assign bus.valid    = valid_q;
  assign bus.overrun  = ovr_q;
  assign dbg_state_o  = state_q;

endmodule
